// File: rtl/xge_tx_arb_pkg.sv
// Shared types and width defaults for the xge TX arbiter.
package xge_tx_arb_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int MOD_W_DEF  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

endpackage

// File: rtl/xge_rr_picker.sv
// Combinational round-robin select: first asserted req at or above ptr, wrapping.
module xge_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               vld
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt = '0;
      vld = 1'b0;
      sum = '0;
      idx = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(off);
         if (sum >= (PTR_W+1)'(NUM_REQ))
            sum = sum - (PTR_W+1)'(NUM_REQ);
         idx = sum[PTR_W-1:0];
         if (!vld && req[idx]) begin
            gnt[idx] = 1'b1;
            vld      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Packet-granular round-robin arbiter onto the xge_mac pkt_tx_* port.
// Optional XGE_TX_ARB_STATS_EN adds per-requester eop counters and stat_* ports.
module xge_tx_arbiter
   import xge_tx_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MOD_W   = MOD_W_DEF
) (
   input  logic                      clk_156m25,
   input  logic                      reset_156m25,
   input  logic [NUM_REQ*DATA_W-1:0] req_tx_data,
   input  logic [NUM_REQ*MOD_W-1:0]  req_tx_mod,
   input  logic [NUM_REQ-1:0]        req_tx_sop,
   input  logic [NUM_REQ-1:0]        req_tx_eop,
   input  logic [NUM_REQ-1:0]        req_tx_val,
   output logic [NUM_REQ-1:0]        req_tx_ready,
   input  logic                      pkt_tx_full,
   output logic [DATA_W-1:0]         pkt_tx_data,
   output logic [MOD_W-1:0]          pkt_tx_mod,
   output logic                      pkt_tx_sop,
   output logic                      pkt_tx_eop,
   output logic                      pkt_tx_val,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      drop_err
`ifdef XGE_TX_ARB_STATS_EN
   ,
   input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
   output logic [31:0]                stat_pkt_cnt
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);

   arb_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] cand, pick;
   logic               pick_vld;
   logic [PTR_W-1:0]   rr_ptr, g_idx, ptr_nxt;
   logic               acc, drop;

   assign cand = req_tx_val & req_tx_sop;

   xge_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
      .req (cand),
      .ptr (rr_ptr),
      .gnt (pick),
      .vld (pick_vld)
   );

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) g_idx = PTR_W'(i);
      ptr_nxt = (g_idx == PTR_W'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;
   end

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) state <= IDLE;
      else              state <= state_nxt;
   end

   // Stray non-sop words in IDLE are swallowed so a confused source cannot stall.
   always_comb begin
      state_nxt    = state;
      req_tx_ready = '0;
      acc          = 1'b0;
      drop         = 1'b0;
      case (state)
         IDLE: begin
            req_tx_ready = req_tx_val & ~req_tx_sop;
            drop         = |(req_tx_val & ~req_tx_sop);
            if (pick_vld) state_nxt = XFER;
         end
         XFER: begin
            req_tx_ready = grant & {NUM_REQ{~pkt_tx_full}};
            acc          = req_tx_val[g_idx] & ~pkt_tx_full;
            if (acc && req_tx_eop[g_idx]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         grant       <= '0;
         rr_ptr      <= '0;
         pkt_tx_data <= '0;
         pkt_tx_mod  <= '0;
         pkt_tx_sop  <= 1'b0;
         pkt_tx_eop  <= 1'b0;
         pkt_tx_val  <= 1'b0;
         drop_err    <= 1'b0;
      end else begin
         drop_err   <= drop;
         pkt_tx_val <= acc;
         if (acc) begin
            pkt_tx_data <= req_tx_data[int'(g_idx)*DATA_W +: DATA_W];
            pkt_tx_mod  <= req_tx_mod[int'(g_idx)*MOD_W +: MOD_W];
            pkt_tx_sop  <= req_tx_sop[g_idx];
            pkt_tx_eop  <= req_tx_eop[g_idx];
         end
         if (state == IDLE && pick_vld) begin
            grant <= pick;
         end else if (acc && req_tx_eop[g_idx]) begin
            grant  <= '0;
            rr_ptr <= ptr_nxt;
         end
      end
   end

`ifdef XGE_TX_ARB_STATS_EN
   logic [31:0] stat_cnt [NUM_REQ];

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
         stat_pkt_cnt <= '0;
      end else begin
         if (acc && req_tx_eop[g_idx]) stat_cnt[g_idx] <= stat_cnt[g_idx] + 32'd1;
         stat_pkt_cnt <= (int'(stat_sel) < NUM_REQ) ? stat_cnt[stat_sel] : '0;
      end
   end
`endif

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Directed bench for xge_tx_arbiter: queued packet sources, output log, hand-derived expectations.
module tb_xge_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 64;
   localparam int MOD_W   = 3;

   logic                      clk_156m25 = 1'b0;
   logic                      reset_156m25;
   logic [NUM_REQ*DATA_W-1:0] req_tx_data;
   logic [NUM_REQ*MOD_W-1:0]  req_tx_mod;
   logic [NUM_REQ-1:0]        req_tx_sop, req_tx_eop, req_tx_val, req_tx_ready;
   logic                      pkt_tx_full;
   logic [DATA_W-1:0]         pkt_tx_data;
   logic [MOD_W-1:0]          pkt_tx_mod;
   logic                      pkt_tx_sop, pkt_tx_eop, pkt_tx_val;
   logic [NUM_REQ-1:0]        grant;
   logic                      drop_err;
`ifdef XGE_TX_ARB_STATS_EN
   logic [1:0]                stat_sel;
   logic [31:0]               stat_pkt_cnt;
`endif

   xge_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
      .clk_156m25   (clk_156m25),
      .reset_156m25 (reset_156m25),
      .req_tx_data  (req_tx_data),
      .req_tx_mod   (req_tx_mod),
      .req_tx_sop   (req_tx_sop),
      .req_tx_eop   (req_tx_eop),
      .req_tx_val   (req_tx_val),
      .req_tx_ready (req_tx_ready),
      .pkt_tx_full  (pkt_tx_full),
      .pkt_tx_data  (pkt_tx_data),
      .pkt_tx_mod   (pkt_tx_mod),
      .pkt_tx_sop   (pkt_tx_sop),
      .pkt_tx_eop   (pkt_tx_eop),
      .pkt_tx_val   (pkt_tx_val),
      .grant        (grant),
      .drop_err     (drop_err)
`ifdef XGE_TX_ARB_STATS_EN
      ,
      .stat_sel     (stat_sel),
      .stat_pkt_cnt (stat_pkt_cnt)
`endif
   );

   always #5 clk_156m25 = ~clk_156m25;

   typedef struct {
      logic [63:0] d;
      logic [2:0]  m;
      logic        sop;
      logic        eop;
   } word_t;

   typedef struct {
      int          stamp;
      logic [63:0] d;
      logic [2:0]  m;
      logic        sop;
      logic        eop;
      logic [3:0]  gnt;
   } out_t;

   word_t              srcq [NUM_REQ][$];
   out_t               olog [$];
   int                 stamp = 0;
   int                 nvec  = 0;
   int                 nerr  = 0;
   logic [NUM_REQ-1:0] rdy_seen;

   task automatic push_pkt(input int r, input int len, input logic [63:0] base);
      word_t w;
      for (int k = 0; k < len; k++) begin
         w.d   = base + 64'(k);
         w.m   = 3'(k);
         w.sop = (k == 0);
         w.eop = (k == len-1);
         srcq[r].push_back(w);
      end
   endtask

   // One clock: present queue heads, sample ready mid-cycle, pop and log after the edge.
   task automatic step();
      word_t              w;
      logic [NUM_REQ-1:0] acc_seen;
      out_t               o;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (srcq[i].size() > 0) begin
            w = srcq[i][0];
            req_tx_data[i*DATA_W +: DATA_W] = w.d;
            req_tx_mod[i*MOD_W +: MOD_W]    = w.m;
            req_tx_sop[i] = w.sop;
            req_tx_eop[i] = w.eop;
            req_tx_val[i] = 1'b1;
         end else begin
            req_tx_sop[i] = 1'b0;
            req_tx_eop[i] = 1'b0;
            req_tx_val[i] = 1'b0;
         end
      end
      @(negedge clk_156m25);
      rdy_seen = req_tx_ready;
      acc_seen = req_tx_val & req_tx_ready;
      @(posedge clk_156m25);
      #1;
      stamp++;
      for (int i = 0; i < NUM_REQ; i++)
         if (acc_seen[i] && !reset_156m25) void'(srcq[i].pop_front());
      if (pkt_tx_val === 1'b1) begin
         o.stamp = stamp; o.d = pkt_tx_data; o.m = pkt_tx_mod;
         o.sop = pkt_tx_sop; o.eop = pkt_tx_eop; o.gnt = grant;
         olog.push_back(o);
      end
   endtask

   task automatic run_until(input int n, input int budget);
      int k;
      k = 0;
      while (olog.size() < n && k < budget) begin
         step();
         k++;
      end
      nvec++;
      if (olog.size() < n) begin
         nerr++;
         $display("FAIL timeout: got %0d words, want %0d", olog.size(), n);
      end
   endtask

   task automatic do_reset();
      reset_156m25 = 1'b1;
      pkt_tx_full  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
      step();
      step();
      reset_156m25 = 1'b0;
      olog.delete();
   endtask

   task automatic test_reset();
      do_reset();
      nvec++;
      if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err} !== 4'b0 || grant !== 4'b0 ||
          pkt_tx_data !== 64'h0 || pkt_tx_mod !== 3'h0) begin
         nerr++;
         $display("FAIL reset_outputs: got val=%b gnt=%b data=%h, want all 0", pkt_tx_val, grant, pkt_tx_data);
      end
   endtask

   task automatic test_single_packet();
      int s;
      do_reset();
      s = stamp;
      push_pkt(0, 3, 64'hA000);
      run_until(3, 20);
      for (int k = 0; k < 3 && k < olog.size(); k++) begin
         nvec++;
         if (olog[k].stamp !== s+2+k || olog[k].d !== 64'hA000 + 64'(k) || olog[k].m !== 3'(k) ||
             olog[k].sop !== (k == 0) || olog[k].eop !== (k == 2)) begin
            nerr++;
            $display("FAIL pkt3_word%0d: got t=%0d d=%h m=%0d sop=%b eop=%b, want t=%0d d=%h",
                     k, olog[k].stamp - s, olog[k].d, olog[k].m, olog[k].sop, olog[k].eop, 2+k, 64'hA000 + 64'(k));
         end
      end
      if (olog.size() == 3) begin
         nvec++;
         if (olog[0].gnt !== 4'b0001 || olog[2].gnt !== 4'b0000) begin
            nerr++;
            $display("FAIL pkt3_grant: got %b/%b, want 0001/0000", olog[0].gnt, olog[2].gnt);
         end
      end
   endtask

   task automatic test_round_robin();
      int s;
      int ord [5] = '{0, 1, 2, 3, 0};
      int pk  [5] = '{0, 0, 0, 0, 1};
      logic [63:0] exp_d;
      do_reset();
      s = stamp;
      for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 2, 64'h0200_0000 + 64'(i*16));
      push_pkt(0, 2, 64'h0200_0008);
      run_until(10, 60);
      for (int p = 0; p < 5; p++)
         for (int k = 0; k < 2; k++)
            if (olog.size() > 2*p+k) begin
               exp_d = 64'h0200_0000 + 64'(ord[p]*16 + pk[p]*8 + k);
               nvec++;
               if (olog[2*p+k].d !== exp_d || olog[2*p+k].stamp !== s+2+3*p+k) begin
                  nerr++;
                  $display("FAIL rr_pkt%0d_word%0d: got d=%h t=%0d, want d=%h t=%0d",
                           p, k, olog[2*p+k].d, olog[2*p+k].stamp - s, exp_d, 2+3*p+k);
               end
            end
   endtask

   task automatic test_backpressure();
      int s;
      do_reset();
      s = stamp;
      push_pkt(0, 6, 64'hB000);
      run_until(2, 20);
      pkt_tx_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         nvec++;
         if (rdy_seen[0] !== 1'b0 || pkt_tx_val !== 1'b0 || pkt_tx_data !== 64'hB001) begin
            nerr++;
            $display("FAIL full_cycle%0d: got rdy=%b val=%b d=%h, want 0 0 %h", k, rdy_seen[0], pkt_tx_val, pkt_tx_data, 64'hB001);
         end
      end
      pkt_tx_full = 1'b0;
      run_until(6, 20);
      for (int k = 0; k < 6 && k < olog.size(); k++) begin
         nvec++;
         if (olog[k].d !== 64'hB000 + 64'(k)) begin
            nerr++;
            $display("FAIL full_word%0d: got %h, want %h", k, olog[k].d, 64'hB000 + 64'(k));
         end
      end
      if (olog.size() >= 3) begin
         nvec++;
         if (olog[2].stamp !== s+9 || olog.size() !== 6) begin
            nerr++;
            $display("FAIL full_resume: got t=%0d n=%0d, want t=9 n=6", olog[2].stamp - s, olog.size());
         end
      end
   endtask

   task automatic test_stray_drop();
      word_t w;
      do_reset();
      w.d = 64'hDEAD; w.m = 3'd0; w.sop = 1'b0; w.eop = 1'b1;
      srcq[2].push_back(w);
      step();
      nvec++;
      if (rdy_seen !== 4'b0100 || drop_err !== 1'b1 || grant !== 4'b0 || pkt_tx_val !== 1'b0) begin
         nerr++;
         $display("FAIL stray_drop: got rdy=%b drop=%b gnt=%b val=%b, want 0100 1 0000 0", rdy_seen, drop_err, grant, pkt_tx_val);
      end
      step();
      nvec++;
      if (drop_err !== 1'b0 || srcq[2].size() !== 0 || olog.size() !== 0) begin
         nerr++;
         $display("FAIL stray_pulse: got drop=%b q=%0d out=%0d, want 0 0 0", drop_err, srcq[2].size(), olog.size());
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      push_pkt(2, 1, 64'hC200);
      run_until(1, 10);
      step();
      push_pkt(3, 4, 64'hC300);
      run_until(3, 20);
      reset_156m25 = 1'b1;
      step();
      nvec++;
      if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, drop_err} !== 4'b0 || grant !== 4'b0 ||
          pkt_tx_data !== 64'h0 || pkt_tx_mod !== 3'h0) begin
         nerr++;
         $display("FAIL midreset_outputs: got val=%b gnt=%b data=%h, want all 0", pkt_tx_val, grant, pkt_tx_data);
      end
      reset_156m25 = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
      olog.delete();
      push_pkt(1, 1, 64'hD100);
      push_pkt(3, 1, 64'hD300);
      run_until(2, 20);
      if (olog.size() == 2) begin
         nvec++;
         if (olog[0].d !== 64'hD100 || olog[1].d !== 64'hD300) begin
            nerr++;
            $display("FAIL midreset_ptr: got %h,%h, want %h,%h", olog[0].d, olog[1].d, 64'hD100, 64'hD300);
         end
      end
   endtask

`ifdef XGE_TX_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      stat_sel = 2'd1;
      for (int p = 0; p < 7; p++) push_pkt(1, 1, 64'hE000 + 64'(p));
      run_until(7, 40);
      step();
      step();
      nvec++;
      if (stat_pkt_cnt !== 32'd7) begin
         nerr++;
         $display("FAIL stat_cnt7: got %0d, want 7", stat_pkt_cnt);
      end
      dut.stat_cnt[0] = 32'hFFFF_FFFF;
      stat_sel = 2'd0;
      push_pkt(0, 1, 64'hE100);
      run_until(8, 10);
      step();
      step();
      nvec++;
      if (stat_pkt_cnt !== 32'd0) begin
         nerr++;
         $display("FAIL stat_wrap: got %h, want 0", stat_pkt_cnt);
      end
   endtask
`endif

   initial begin
      reset_156m25 = 1'b1;
      pkt_tx_full  = 1'b0;
      req_tx_data  = '0;
      req_tx_mod   = '0;
      req_tx_sop   = '0;
      req_tx_eop   = '0;
      req_tx_val   = '0;
`ifdef XGE_TX_ARB_STATS_EN
      stat_sel     = '0;
`endif
      test_reset();
      test_single_packet();
      test_round_robin();
      test_backpressure();
      test_stray_drop();
      test_reset_mid_packet();
`ifdef XGE_TX_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
